// File: rtl/forwarding_scoreboard_pkg.sv
// Shared constants and helpers for the forwarding/hazard scoreboard.
package forwarding_scoreboard_pkg;

  // srcSelEx encoding: 0 reads the register file, k forwards from shadow stage k
  localparam int unsigned FWD_SEL_REGFILE = 0;

  // Shadow stage indices counted from the first stage after ID
  localparam int unsigned STAGE_EX  = 0;
  localparam int unsigned STAGE_MEM = 1;

  // Shadow entry layout, LSB first: {dest, wbEn, isLoad}
  localparam int unsigned ENT_ISLOAD_BIT = 0;
  localparam int unsigned ENT_WBEN_BIT   = 1;
  localparam int unsigned ENT_DEST_LSB   = 2;

  // Width of one shadow entry
  function automatic int unsigned ent_width(input int unsigned reg_addr_w);
    return reg_addr_w + ENT_DEST_LSB;
  endfunction

  // Width of a forwarding select for a given number of shadow stages
  function automatic int unsigned sel_width(input int unsigned num_stages);
    return (num_stages <= 2) ? 1 : $clog2(num_stages);
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// ID-stage issue bus and forwarding/hazard results of the scoreboard.
interface forwarding_scoreboard_if #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STALL_CNT_W = 16
);
  import forwarding_scoreboard_pkg::*;

  localparam int unsigned SEL_W = sel_width(NUM_STAGES);

  logic                          forwardingEnabled;
  logic                          freeze;
  logic                          flush;
  logic                          issueValid;
  logic                          issueWbEn;
  logic [REG_ADDR_W-1:0]         issueDest;
  logic                          issueIsLoad;
  logic [NUM_SRC-1:0]            srcValid;
  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddr;
  logic                          hazard;
  logic [NUM_SRC*SEL_W-1:0]      srcSelEx;
  logic [STALL_CNT_W-1:0]        stallCount;

  // Pipeline control side
  modport master (
    output forwardingEnabled, freeze, flush, issueValid, issueWbEn, issueDest,
           issueIsLoad, srcValid, srcAddr,
    input  hazard, srcSelEx, stallCount
  );

  // Scoreboard side
  modport slave (
    input  forwardingEnabled, freeze, flush, issueValid, issueWbEn, issueDest,
           issueIsLoad, srcValid, srcAddr,
    output hazard, srcSelEx, stallCount
  );

endinterface

// File: rtl/forwarding_scoreboard_match_slice.sv
// Compares one ID source against every shadow stage.
module fwd_match_slice
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                                        i_fwd_en,
  input  logic                                        i_issue_valid,
  input  logic                                        i_src_valid,
  input  logic [REG_ADDR_W-1:0]                       i_src_addr,
  input  logic [NUM_STAGES*ent_width(REG_ADDR_W)-1:0] i_stages,
  output logic [SEL_W-1:0]                            o_sel_next_c,
  output logic                                        o_load_use_c,
  output logic                                        o_stall_nofwd_c
);

  localparam int unsigned ENT_W = ent_width(REG_ADDR_W);

  logic [NUM_STAGES-1:0] w_match;
  logic [NUM_STAGES-1:0] w_is_load;
  logic                  w_unused;

  // Per-stage address match against live writers
  always_comb begin
    w_match   = '0;
    w_is_load = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      w_is_load[k] = i_stages[k*ENT_W + ENT_ISLOAD_BIT];
      w_match[k]   = i_issue_valid & i_src_valid & i_stages[k*ENT_W + ENT_WBEN_BIT] &
                     (i_stages[k*ENT_W + ENT_DEST_LSB +: REG_ADDR_W] == i_src_addr);
    end
  end

  // Hazard flags: a load in EX cannot forward yet; without forwarding, wait for WB
  always_comb begin
    o_load_use_c    = w_match[STAGE_EX] & w_is_load[STAGE_EX];
    o_stall_nofwd_c = |w_match[NUM_STAGES-2:0];
  end

  // Next-cycle select: producer in stage k-1 lands in stage k; youngest wins
  always_comb begin
    o_sel_next_c = SEL_W'(FWD_SEL_REGFILE);
    for (int k = int'(NUM_STAGES) - 1; k >= 1; k--) begin
      if (w_match[k-1]) o_sel_next_c = SEL_W'(k);
    end
    if (!i_fwd_en) o_sel_next_c = SEL_W'(FWD_SEL_REGFILE);
  end

  // WB-stage match and older load flags never affect the result
  assign w_unused = ^{w_is_load[NUM_STAGES-1:1], w_match[NUM_STAGES-1]};

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding/hazard controller: shadow writer pipeline, EX select registers, stall counter.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  forwarding_scoreboard_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_STAGES);
  localparam int unsigned ENT_W = ent_width(REG_ADDR_W);
  localparam int unsigned SHIFT_W = (NUM_STAGES - 1) * ENT_W;

  logic [NUM_STAGES*ENT_W-1:0] r_stages;
  logic [NUM_SRC*SEL_W-1:0]    r_src_sel_ex;
  logic [STALL_CNT_W-1:0]      r_stall_count;
  logic [NUM_SRC*SEL_W-1:0]    w_sel_next;
  logic [NUM_SRC-1:0]          w_load_use;
  logic [NUM_SRC-1:0]          w_stall_nofwd;
  logic                        w_raw_hazard;
  logic                        w_hazard;
  logic                        w_issue_ok;
  logic [ENT_W-1:0]            w_issue_entry;

  // One comparator slice per source operand
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
    fwd_match_slice #(
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_slice (
      .i_fwd_en        (bus.forwardingEnabled),
      .i_issue_valid   (bus.issueValid),
      .i_src_valid     (bus.srcValid[i]),
      .i_src_addr      (bus.srcAddr[i*REG_ADDR_W +: REG_ADDR_W]),
      .i_stages        (r_stages),
      .o_sel_next_c    (w_sel_next[i*SEL_W +: SEL_W]),
      .o_load_use_c    (w_load_use[i]),
      .o_stall_nofwd_c (w_stall_nofwd[i])
    );
  end

  // Hazard reduction; a flushed ID instruction never stalls
  always_comb begin
    w_raw_hazard  = bus.forwardingEnabled ? (|w_load_use) : (|w_stall_nofwd);
    w_hazard      = w_raw_hazard & ~bus.flush;
    w_issue_ok    = bus.issueValid & ~w_hazard & ~bus.flush;
    w_issue_entry = {bus.issueDest, bus.issueWbEn, bus.issueIsLoad};
  end

  // Shadow writer pipeline: shift on advance, bubble when ID does not issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stages <= '0;
    end else if (!bus.freeze) begin
      r_stages[STAGE_MEM*ENT_W +: SHIFT_W] <= r_stages[STAGE_EX*ENT_W +: SHIFT_W];
      r_stages[STAGE_EX*ENT_W +: ENT_W]    <= w_issue_ok ? w_issue_entry : '0;
    end
  end

  // EX forwarding selects, aligned with the instruction entering EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src_sel_ex <= '0;
    end else if (!bus.freeze) begin
      r_src_sel_ex <= w_issue_ok ? w_sel_next : '0;
    end
  end

  // Saturating count of non-frozen stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (!bus.freeze && w_hazard && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign bus.hazard     = w_hazard;
  assign bus.srcSelEx   = r_src_sel_ex;
  assign bus.stallCount = r_stall_count;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard with an expected-select scoreboard queue.
module tb_forwarding_scoreboard;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  forwarding_scoreboard_if #(.REG_ADDR_W(4), .NUM_SRC(2), .NUM_STAGES(3), .STALL_CNT_W(16)) bus ();
  forwarding_scoreboard_if #(.REG_ADDR_W(4), .NUM_SRC(2), .NUM_STAGES(3), .STALL_CNT_W(2))  bus2 ();

  forwarding_scoreboard #(.REG_ADDR_W(4), .NUM_SRC(2), .NUM_STAGES(3), .STALL_CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  forwarding_scoreboard #(.REG_ADDR_W(4), .NUM_SRC(2), .NUM_STAGES(3), .STALL_CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_sel_q[$];
  logic [3:0]  exp_sel;
  logic [15:0] exp_stall;
  logic [1:0]  exp_sat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic we, input logic [3:0] d, input logic ld,
                       input logic [1:0] sv, input logic [3:0] a0, input logic [3:0] a1);
    bus.issueValid  = v;
    bus.issueWbEn   = we;
    bus.issueDest   = d;
    bus.issueIsLoad = ld;
    bus.srcValid    = sv;
    bus.srcAddr     = {a1, a0};
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.forwardingEnabled = 1'b1; bus.freeze = 1'b0; bus.flush = 1'b0;
    bus2.forwardingEnabled = 1'b0; bus2.freeze = 1'b0; bus2.flush = 1'b0;
    bus2.issueValid = 1'b0; bus2.issueWbEn = 1'b0; bus2.issueDest = 4'd0;
    bus2.issueIsLoad = 1'b0; bus2.srcValid = 2'b00; bus2.srcAddr = 8'd0;
    issue(1'b1, 1'b1, 4'd3, 1'b1, 2'b01, 4'd3, 4'd0);
    #2;
    n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL rst_hazard: got %b want 0", bus.hazard); end
    n_cmp++; if (bus.srcSelEx !== 4'd0) begin n_err++; $display("FAIL rst_sel: got %h want 0", bus.srcSelEx); end
    n_cmp++; if (bus.stallCount !== 16'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", bus.stallCount); end
    tick();
    n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL rst_hold_hazard: got %b want 0", bus.hazard); end
    n_cmp++; if (bus.srcSelEx !== 4'd0) begin n_err++; $display("FAIL rst_hold_sel: got %h want 0", bus.srcSelEx); end
    idle();
    #5 rst = 1'b1;
    tick();
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use();
    issue(1'b1, 1'b1, 4'd3, 1'b1, 2'b00, 4'd0, 4'd0);
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL lu_load_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0000);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL lu_load_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd3, 4'd0);
    #1; n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL lu_hazard: got %b want 1", bus.hazard); end
    exp_sel_q.push_back(4'b0000); exp_stall++;
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL lu_bubble_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL lu_stall: got %0d want %0d", bus.stallCount, exp_stall); end
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL lu_one_cycle: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0010);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL lu_fwd_wb: got %h want %h", bus.srcSelEx, exp_sel); end
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL lu_stall_after: got %0d want %0d", bus.stallCount, exp_stall); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tab [4] = '{4'b0000, 4'b0100, 4'b1000, 4'b0000};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: issue(1'b1, 1'b1, 4'd1, 1'b0, 2'b00, 4'd0, 4'd0);
        1: issue(1'b1, 1'b1, 4'd9, 1'b0, 2'b10, 4'd7, 4'd1);
        2: issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b10, 4'd0, 4'd1);
        default: issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd1, 4'd0);
      endcase
      #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL b2b_hazard[%0d]: got %b want 0", c, bus.hazard); end
      exp_sel_q.push_back(exp_tab[c]);
      tick(); exp_sel = exp_sel_q.pop_front();
      n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL b2b_sel[%0d]: got %h want %h", c, bus.srcSelEx, exp_sel); end
    end
    drain();
  endtask

  task automatic test_priority();
    issue(1'b1, 1'b1, 4'd5, 1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b1, 4'd5, 1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b11, 4'd5, 4'd5);
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL prio_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0101);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL prio_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    drain();
  endtask

  task automatic test_fwd_off();
    bus.forwardingEnabled = 1'b0;
    issue(1'b1, 1'b1, 4'd2, 1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd2, 4'd0);
    for (int c = 0; c < 3; c++) begin
      #1; n_cmp++; if (bus.hazard !== (c < 2)) begin n_err++; $display("FAIL nofwd_hazard[%0d]: got %b want %b", c, bus.hazard, (c < 2)); end
      exp_sel_q.push_back(4'b0000);
      if (c < 2) exp_stall++;
      tick(); exp_sel = exp_sel_q.pop_front();
      n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL nofwd_sel[%0d]: got %h want %h", c, bus.srcSelEx, exp_sel); end
      n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL nofwd_stall[%0d]: got %0d want %0d", c, bus.stallCount, exp_stall); end
    end
    bus.forwardingEnabled = 1'b1;
    drain();
  endtask

  task automatic test_flush();
    issue(1'b1, 1'b1, 4'd4, 1'b1, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b1, 4'd6, 1'b1, 2'b01, 4'd4, 4'd0);
    bus.flush = 1'b1;
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL flush_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0000);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL flush_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL flush_stall: got %0d want %0d", bus.stallCount, exp_stall); end
    bus.flush = 1'b0;
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b11, 4'd4, 4'd6);
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL flush_bubble_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0010);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL flush_bubble_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    drain();
  endtask

  task automatic test_freeze();
    issue(1'b1, 1'b1, 4'd8, 1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b1, 4'd7, 1'b1, 2'b10, 4'd0, 4'd8);
    exp_sel_q.push_back(4'b0100);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL frz_pre_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd7, 4'd0);
    bus.freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL frz_hazard[%0d]: got %b want 1", c, bus.hazard); end
      exp_sel_q.push_back(4'b0100);
      tick(); exp_sel = exp_sel_q.pop_front();
      n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL frz_sel[%0d]: got %h want %h", c, bus.srcSelEx, exp_sel); end
      n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL frz_stall[%0d]: got %0d want %0d", c, bus.stallCount, exp_stall); end
    end
    bus.freeze = 1'b0;
    #1; n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL frz_release_hazard: got %b want 1", bus.hazard); end
    exp_sel_q.push_back(4'b0000); exp_stall++;
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL frz_release_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL frz_release_stall: got %0d want %0d", bus.stallCount, exp_stall); end
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL frz_after_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0010);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL frz_after_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    drain();
  endtask

  task automatic test_src_invalid();
    issue(1'b1, 1'b1, 4'd10, 1'b1, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 4'd10, 4'd10);
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL srcinv_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0000);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL srcinv_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    drain();
  endtask

  task automatic test_saturation();
    exp_sat = 2'd0;
    for (int r = 0; r < 3; r++) begin
      bus2.issueValid = 1'b1; bus2.issueWbEn = 1'b1; bus2.issueDest = 4'(r + 1);
      bus2.srcValid = 2'b00;
      tick();
      bus2.issueWbEn = 1'b0; bus2.srcValid = 2'b01; bus2.srcAddr = {4'd0, 4'(r + 1)};
      for (int c = 0; c < 2; c++) begin
        #1; n_cmp++; if (bus2.hazard !== 1'b1) begin n_err++; $display("FAIL sat_hazard[%0d.%0d]: got %b want 1", r, c, bus2.hazard); end
        if (exp_sat != 2'd3) exp_sat++;
        tick();
        n_cmp++; if (bus2.stallCount !== exp_sat) begin n_err++; $display("FAIL sat_count[%0d.%0d]: got %0d want %0d", r, c, bus2.stallCount, exp_sat); end
      end
      tick();
    end
    bus2.issueValid = 1'b0; bus2.srcValid = 2'b00;
  endtask

  task automatic test_reset_mid_stall();
    bus.forwardingEnabled = 1'b0;
    issue(1'b1, 1'b1, 4'd2, 1'b0, 2'b00, 4'd0, 4'd0);
    tick();
    issue(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd2, 4'd0);
    #1; n_cmp++; if (bus.hazard !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_hazard: got %b want 1", bus.hazard); end
    exp_stall++;
    tick();
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL rstmid_pre_stall: got %0d want %0d", bus.stallCount, exp_stall); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL rstmid_hazard: got %b want 0", bus.hazard); end
    n_cmp++; if (bus.stallCount !== 16'd0) begin n_err++; $display("FAIL rstmid_stall: got %0d want 0", bus.stallCount); end
    n_cmp++; if (bus.srcSelEx !== 4'd0) begin n_err++; $display("FAIL rstmid_sel: got %h want 0", bus.srcSelEx); end
    exp_stall = 16'd0;
    exp_sel_q.delete();
    #1 rst = 1'b1;
    #1; n_cmp++; if (bus.hazard !== 1'b0) begin n_err++; $display("FAIL rstmid_post_hazard: got %b want 0", bus.hazard); end
    exp_sel_q.push_back(4'b0000);
    tick(); exp_sel = exp_sel_q.pop_front();
    n_cmp++; if (bus.srcSelEx !== exp_sel) begin n_err++; $display("FAIL rstmid_post_sel: got %h want %h", bus.srcSelEx, exp_sel); end
    n_cmp++; if (bus.stallCount !== exp_stall) begin n_err++; $display("FAIL rstmid_post_stall: got %0d want %0d", bus.stallCount, exp_stall); end
    bus.forwardingEnabled = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_priority();
    test_fwd_off();
    test_flush();
    test_freeze();
    test_src_invalid();
    test_saturation();
    test_reset_mid_stall();
    if (exp_sel_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_sel_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
